spi_tx_arbiter: RTL and testbench

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_shifter.sv | 98 +++++++++
 rtl/spi_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_tx_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the two-requester SPI transmit arbiter.
// Holds the frame FSM encoding, default geometry and the round-robin pick rule.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_CLK_DIV = 4;
    localparam int unsigned DIV_W       = 8;

    localparam logic REQ_SW  = 1'b0;
    localparam logic REQ_BTN = 1'b1;

    // Index of the requester to grant; on a tie the one not granted last wins.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last);
        logic pick;
        if (valid == 2'b11) begin
            pick = ~last;
        end else if (valid[0]) begin
            pick = REQ_SW;
        end else begin
            pick = REQ_BTN;
        end
        return pick;
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 serialiser: shared divider, half-period counter, shift register
// and registered sclk/mosi generation, sequenced by the arbiter FSM.
module spi_shifter
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              setup_i,
    input  logic              shift_i,
    input  logic              run_i,
    output logic              tick_o,
    output logic              last_o,
    output logic              sclk_o,
    output logic              mosi_o
);

    localparam int unsigned      CNT_W      = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_HALF  = CNT_W'(2 * DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_FALL  = CNT_W'(2 * DATA_W - 2);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sclk_q, sclk_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tick_s;
    logic              last_s;

    assign tick_s = run_i && (div_q == {DIV_W{1'b0}});
    assign last_s = shift_i && tick_s && (bit_cnt_q == LAST_HALF);

    // Divider, half-period count, clock level and shift data for the next cycle.
    always_comb begin
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        shreg_d   = shreg_q;
        if (load_i) begin
            div_d     = DIV_RELOAD;
            bit_cnt_d = {CNT_W{1'b0}};
            sclk_d    = 1'b0;
            shreg_d   = data_i;
        end else if (tick_s) begin
            div_d = DIV_RELOAD;
            if (setup_i) begin
                sclk_d = 1'b1;
            end else if (shift_i) begin
                bit_cnt_d = bit_cnt_q + CNT_ONE;
                if (last_s) begin
                    sclk_d  = 1'b0;
                    shreg_d = {DATA_W{1'b0}};
                end else begin
                    sclk_d = ~sclk_q;
                    // Data moves on falling edges only; the last bit stays put through the final low half.
                    if (sclk_q && (bit_cnt_q != LAST_FALL)) begin
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    end else begin
                        shreg_d = shreg_q;
                    end
                end
            end else begin
                sclk_d = sclk_q;
            end
        end else if (run_i) begin
            div_d = div_q - DIV_ONE;
        end else begin
            div_d = div_q;
        end
    end

    // Serialiser state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q     <= {DIV_W{1'b0}};
            bit_cnt_q <= {CNT_W{1'b0}};
            sclk_q    <= 1'b0;
            shreg_q   <= {DATA_W{1'b0}};
        end else begin
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            shreg_q   <= shreg_d;
        end
    end

    assign tick_o = tick_s;
    assign last_o = last_s;
    assign sclk_o = sclk_q;
    assign mosi_o = shreg_q[DATA_W-1];

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter between two frame requesters feeding one SPI mode-0
// transmitter; owns the frame FSM and chip select, delegates bit timing.
module spi_tx_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    output logic              busy,
    output logic              frame_src,
    output logic              frame_done
);

    spi_state_e state_q, state_d;
    logic       en_q;
    logic       last_q, last_d;
    logic       src_q, src_d;
    logic       cs_n_q, cs_n_d;

    logic              grant_s;
    logic              accept_s;
    logic              load_s;
    logic              setup_s;
    logic              shift_s;
    logic              run_s;
    logic              tick_s;
    logic              last_s;
    logic [DATA_W-1:0] load_data_s;

    assign grant_s     = rr_pick(req_valid, last_q);
    assign load_data_s = grant_s ? req_data1 : req_data0;

    // FSM state register; en_q keeps req_ready low until the first cycle after reset release.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_SETUP;
                else          state_d = ST_IDLE;
            end
            ST_SETUP: begin
                if (tick_s) state_d = ST_SHIFT;
                else        state_d = ST_SETUP;
            end
            ST_SHIFT: begin
                if (last_s) state_d = ST_HOLD;
                else        state_d = ST_SHIFT;
            end
            ST_HOLD: begin
                if (tick_s) state_d = ST_IDLE;
                else        state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        accept_s   = 1'b0;
        req_ready  = 2'b00;
        setup_s    = 1'b0;
        shift_s    = 1'b0;
        run_s      = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q && (req_valid != 2'b00)) begin
                    accept_s  = 1'b1;
                    req_ready = grant_s ? 2'b10 : 2'b01;
                    busy      = 1'b1;
                end else begin
                    accept_s  = 1'b0;
                    req_ready = 2'b00;
                    busy      = 1'b0;
                end
            end
            ST_SETUP: begin
                setup_s = 1'b1;
                run_s   = 1'b1;
                busy    = 1'b1;
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                run_s   = 1'b1;
                busy    = 1'b1;
            end
            ST_HOLD: begin
                run_s      = 1'b1;
                busy       = 1'b1;
                frame_done = tick_s;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign load_s = accept_s;

    // Grant pointer, frame owner and chip select for the next cycle.
    always_comb begin
        last_d = last_q;
        src_d  = src_q;
        cs_n_d = cs_n_q;
        if (load_s) begin
            last_d = grant_s;
            src_d  = grant_s;
            cs_n_d = 1'b0;
        end else if (last_s) begin
            cs_n_d = 1'b1;
        end else begin
            cs_n_d = cs_n_q;
        end
    end

    // Frame bookkeeping registers.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            last_q <= REQ_BTN;
            src_q  <= REQ_SW;
            cs_n_q <= 1'b1;
        end else begin
            last_q <= last_d;
            src_q  <= src_d;
            cs_n_q <= cs_n_d;
        end
    end

    spi_shifter #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_i   (sys_clock),
        .rst_i   (reset),
        .load_i  (load_s),
        .data_i  (load_data_s),
        .setup_i (setup_s),
        .shift_i (shift_s),
        .run_i   (run_s),
        .tick_o  (tick_s),
        .last_o  (last_s),
        .sclk_o  (spi_sclk),
        .mosi_o  (spi_mosi)
    );

    assign spi_cs_n  = cs_n_q;
    assign frame_src = src_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboarded bench for spi_tx_arbiter: default geometry instance plus a
// CLK_DIV=1, DATA_W=2 instance for the minimum-size frame.
module tb_spi_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] a_valid, a_ready;
    logic [7:0] a_d0, a_d1;
    logic       a_sclk, a_mosi, a_csn, a_busy, a_src, a_done;

    logic [1:0] b_valid, b_ready;
    logic [1:0] b_d0, b_d1;
    logic       b_sclk, b_mosi, b_csn, b_busy, b_src, b_done;

    spi_tx_arbiter dut_a (
        .sys_clock (clk),     .reset      (rst),
        .req_valid (a_valid), .req_data0  (a_d0),  .req_data1 (a_d1),
        .req_ready (a_ready), .spi_sclk   (a_sclk), .spi_mosi (a_mosi),
        .spi_cs_n  (a_csn),   .busy       (a_busy), .frame_src (a_src),
        .frame_done(a_done)
    );

    spi_tx_arbiter #(.DATA_W(2), .CLK_DIV(1)) dut_b (
        .sys_clock (clk),     .reset      (rst),
        .req_valid (b_valid), .req_data0  (b_d0),  .req_data1 (b_d1),
        .req_ready (b_ready), .spi_sclk   (b_sclk), .spi_mosi (b_mosi),
        .spi_cs_n  (b_csn),   .busy       (b_busy), .frame_src (b_src),
        .frame_done(b_done)
    );

    int checks = 0;
    int errors = 0;
    int rdy_cnt = 0;

    logic [8:0] exp_q[$];
    logic [7:0] pend0[$];
    logic [7:0] pend1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 || pend0.size() != 0 || pend1.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > maxc) begin
                timeout(tag);
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // Requester model: holds valid/data until the accept edge, then moves to the next payload.
    initial begin
        logic [1:0] acc;
        acc     = 2'b00;
        a_valid = 2'b00;
        a_d0    = 8'h00;
        a_d1    = 8'h00;
        forever begin
            @(negedge clk);
            if (acc[0] && pend0.size() != 0) void'(pend0.pop_front());
            if (acc[1] && pend1.size() != 0) void'(pend1.pop_front());
            a_valid = {pend1.size() != 0, pend0.size() != 0};
            a_d0    = (pend0.size() != 0) ? pend0[0] : 8'h00;
            a_d1    = (pend1.size() != 0) ? pend1[0] : 8'h00;
            #1;
            acc = rst ? 2'b00 : (a_valid & a_ready);
            if (a_ready != 2'b00) begin
                check("ready_onehot", 32'($onehot(a_ready)), 32'd1);
                check("ready_only_idle", 32'(a_csn), 32'd1);
                rdy_cnt++;
            end
        end
    end

    logic [7:0] mon_acc;
    logic [8:0] mon_e;
    int         mon_nb, cs_low, gap;
    logic       have_prev, sclk_prev;

    // Frame monitor: reassembles MOSI at sclk rising edges and scores each completed frame.
    always @(negedge clk) begin
        if (rst) begin
            mon_acc   = 8'h00;
            mon_nb    = 0;
            cs_low    = 0;
            gap       = 0;
            have_prev = 1'b0;
            rdy_cnt   = 0;
        end else begin
            if (!a_csn) begin
                if (cs_low == 0) begin
                    if (have_prev) check("cs_gap_ge5", 32'(gap >= 5), 32'd1);
                    gap = 0;
                end
                cs_low++;
                if (a_sclk && !sclk_prev) begin
                    mon_acc = {mon_acc[6:0], a_mosi};
                    mon_nb++;
                end
            end else begin
                gap++;
            end
            if (a_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_frame observed=%0h expected=none", mon_acc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("frame_data", 32'(mon_acc), 32'(mon_e[7:0]));
                    check("frame_src", 32'(a_src), 32'(mon_e[8]));
                    check("frame_bits", 32'(mon_nb), 32'd8);
                    check("cs_low_cycles", 32'(cs_low), 32'd68);
                    check("ready_cycles", 32'(rdy_cnt), 32'd1);
                    check("busy_at_done", 32'(a_busy), 32'd1);
                    check("lines_after_frame", 32'({a_csn, a_sclk, a_mosi}), 32'b100);
                end
                mon_acc   = 8'h00;
                mon_nb    = 0;
                cs_low    = 0;
                rdy_cnt   = 0;
                have_prev = 1'b1;
            end
        end
        sclk_prev = a_sclk;
    end

    initial begin
        int         n;
        int         b_low, b_nb, b_dones;
        logic [4:0] b_seq;
        logic [1:0] b_bits;
        logic       b_prev;

        rst     = 1'b1;
        b_valid = 2'b00;
        b_d0    = 2'b00;
        b_d1    = 2'b00;

        // Reset state, with a request already pending that must not be acknowledged.
        pend0.push_back(8'hA5);
        exp_q.push_back({1'b0, 8'hA5});
        repeat (3) @(negedge clk);
        #2;
        check("rst_cs_n", 32'(a_csn), 32'd1);
        check("rst_sclk", 32'(a_sclk), 32'd0);
        check("rst_mosi", 32'(a_mosi), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_src", 32'(a_src), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("cs_n_after_release", 32'(a_csn), 32'd1);
        wait_drain("single_frame", 300);

        // Tie right after reset: requester 0 first, then 1.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pend0.push_back(8'h3C);
        pend1.push_back(8'hC3);
        exp_q.push_back({1'b0, 8'h3C});
        exp_q.push_back({1'b1, 8'hC3});
        wait_drain("simultaneous", 400);

        // Both requesters continuously valid: strict alternation starting at 0.
        for (int i = 0; i < 4; i++) begin
            pend0.push_back(8'h11 * 8'(i + 1));
            pend1.push_back(8'h91 + 8'(i));
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, 8'h11 * 8'(i + 1)});
            exp_q.push_back({1'b1, 8'h91 + 8'(i)});
        end
        wait_drain("fairness", 1200);

        // Late request from requester 1 while requester 0's frame is in flight.
        pend0.push_back(8'h5A);
        exp_q.push_back({1'b0, 8'h5A});
        repeat (12) @(negedge clk);
        pend1.push_back(8'h96);
        exp_q.push_back({1'b1, 8'h96});
        n = 0;
        while (!a_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("late_wait_done");
        @(negedge clk);
        #2;
        check("late_accept_first_idle", 32'(a_ready), 32'b10);
        wait_drain("late_request", 300);

        // Reset 20 cycles into SHIFT aborts the frame; a fresh frame afterwards completes.
        pend1.push_back(8'h77);
        exp_q.push_back({1'b1, 8'h77});
        n = 0;
        while (!a_sclk && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("abort_wait_shift");
        repeat (19) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_cs_n", 32'(a_csn), 32'd1);
        check("abort_sclk", 32'(a_sclk), 32'd0);
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_mosi", 32'(a_mosi), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pend0.push_back(8'hE1);
        exp_q.push_back({1'b0, 8'hE1});
        wait_drain("after_abort", 300);

        // Minimum frame: CLK_DIV=1, DATA_W=2, payload 2'b10.
        @(negedge clk);
        b_valid = 2'b01;
        b_d0    = 2'b10;
        #1;
        check("b_ready", 32'(b_ready), 32'b01);
        b_low   = 0;
        b_nb    = 0;
        b_dones = 0;
        b_seq   = 5'b00000;
        b_bits  = 2'b00;
        b_prev  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            b_valid = 2'b00;
            if (!b_csn) begin
                b_low++;
                b_seq = {b_seq[3:0], b_sclk};
                if (b_sclk && !b_prev) begin
                    b_bits = {b_bits[0], b_mosi};
                    b_nb++;
                end
            end
            if (b_done) b_dones++;
            b_prev = b_sclk;
        end
        check("b_cs_low_cycles", 32'(b_low), 32'd5);
        check("b_sclk_pattern", 32'(b_seq), 32'b01010);
        check("b_bits", 32'(b_nb), 32'd2);
        check("b_mosi", 32'(b_bits), 32'b10);
        check("b_done_pulses", 32'(b_dones), 32'd1);
        check("b_src", 32'(b_src), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
